apb_reg_bank: RTL
=================

Name: apb_reg_bank

Overview:
- Parametrised APB slave register bank; successor to the fixed 4-register selector in the encoder/decoder front end.
- Provides NUM_REGS read/write configuration registers plus one read-only status word.
- Adds PREADY wait-state insertion, PSLVERR, PSTRB byte lanes, a busy write-lock and per-register write pulses.
- Sits between the APB bus and the ECC core; the core consumes regs_o, start_o and wr_pulse_o.

Parameters:
AMBA_ADDR_WIDTH, 20, PADDR width
AMBA_WORD, 32, data width; multiple of 8
NUM_REGS, 4, number of RW registers (1..15); status register sits at index NUM_REGS
WAIT_STATES, 0, extra access-phase cycles before PREADY (0..15)
ADDR_LSB, 2, lowest decoded PADDR bit

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
PADDR  in  AMBA_ADDR_WIDTH  APB address
PWDATA  in  AMBA_WORD  write data
PSTRB  in  AMBA_WORD/8  write byte strobes
PSEL  in  1  select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write
PRDATA  out  AMBA_WORD  read data, registered
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid only with PREADY
regs_o  out  NUM_REGS*AMBA_WORD  flattened RW registers; reg i at bits [i*AMBA_WORD +: AMBA_WORD]
status_i  in  AMBA_WORD  core status, read at index NUM_REGS
busy_i  in  1  core busy; blocks writes
start_o  out  1  one-cycle go pulse
wr_pulse_o  out  NUM_REGS  one-cycle pulse per successful register write

Behaviour:
Reset:
- Reset is clk/rst as decided: asynchronous, active-low (rst=0 resets).
- PRDATA, regs_o, start_o, wr_pulse_o, PSLVERR, PREADY and the wait counter are all 0 while rst=0.
- Reset mid-transfer aborts the transfer with no register update.

Address decode:
- idx = PADDR[ADDR_LSB +: IDX_W], where IDX_W = clog2(NUM_REGS+1).
- PADDR bits above the index and below ADDR_LSB are ignored (aliasing allowed).

Access timing:
- Setup phase is PSEL=1, PENABLE=0.
- Access phase is PSEL=1, PENABLE=1.
- Wait counter cnt (4 bit) increments each access-phase cycle while cnt < WAIT_STATES.
- PREADY = PSEL & PENABLE & (cnt == WAIT_STATES), combinational from the registered cnt.
- cnt clears on the edge that completes a transfer (PREADY=1) or whenever PSEL=0.
- WAIT_STATES=0 gives a zero-wait transfer: PREADY is high in the first access cycle.

Error rules (PSLVERR = PREADY & err):
- idx > NUM_REGS (read or write) is an error.
- A write to idx == NUM_REGS (status register) is an error.
- Any write with busy_i=1, sampled in the completing cycle, is an error.
- An erroring write changes no register and produces no pulse.
- An erroring read returns PRDATA = 0.

Write:
- Commits on the clk edge ending the cycle with PREADY=1.
- Byte lane b updates only if PSTRB[b]=1. PSTRB=0 is a legal no-op write, but wr_pulse_o[idx] still fires.
- wr_pulse_o[idx] is high for exactly the one cycle after commit.
- Register 0 bit 0 is a self-clearing GO bit:
  - Writing 1 with PSTRB[0]=1 makes start_o high for one cycle after commit.
  - That bit is never stored; it always reads 0. Other register 0 bits store normally.

Read:
- PRDATA loads on every edge in the setup phase with PWRITE=0: reg[idx], status_i, or 0 if out of range.
- PRDATA holds the value through wait states and afterwards, until the next read setup.
- Writes never change PRDATA.

Misc:
- PENABLE without PSEL is ignored.
- PSEL dropped mid-wait aborts the transfer with no side effects.
- Back-to-back transfers are supported; each must see its own setup phase.
- busy_i does not affect reads.

Test Plan:
1. Reset, then write 0xDEADBEEF to idx1 (PADDR=0x4) with PSTRB=0xF, read idx1 -> PRDATA=0xDEADBEEF; wr_pulse_o=4'b0010 for 1 cycle; PSLVERR=0.
2. WAIT_STATES=3: read idx2 -> PREADY low for 3 access cycles, high on the 4th; PRDATA stable throughout.
3. idx1 holds 0xDEADBEEF; write 0x11223344 with PSTRB=4'b0101 -> idx1 reads 0xDE22BE44.
4. Write 0x00000081 to idx0 -> start_o high for exactly 1 cycle; idx0 reads 0x00000080.
5. busy_i=1, write idx2 -> PSLVERR=1 with PREADY, idx2 unchanged, no pulse. Write idx4 (status), NUM_REGS=4 -> PSLVERR=1. Read idx4 with status_i=0xA5 -> PRDATA=0xA5, PSLVERR=0. Read idx6 -> PSLVERR=1, PRDATA=0.
6. WAIT_STATES=3: pull rst low during the 2nd wait cycle of a write to idx3 -> idx3=0 and all outputs 0 immediately; the next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module     : apb_reg_bank
// Description: APB slave with NUM_REGS RW registers and one RO status word.
//              It supports wait states, byte strobes, a busy write-lock and
//              per-register write pulses.
// Revision   : 1.0 - initial release
// ============================================================================
module apb_reg_bank #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int NUM_REGS        = 4,
    parameter int WAIT_STATES     = 0,
    parameter int ADDR_LSB        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
    input  logic [AMBA_WORD-1:0]          PWDATA,
    input  logic [AMBA_WORD/8-1:0]        PSTRB,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    output logic [AMBA_WORD-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [NUM_REGS*AMBA_WORD-1:0] regs_o,
    input  logic [AMBA_WORD-1:0]          status_i,
    input  logic                          busy_i,
    output logic                          start_o,
    output logic [NUM_REGS-1:0]           wr_pulse_o
);

    localparam int               c_idx_w      = $clog2(NUM_REGS + 1);
    localparam int               c_nbytes     = AMBA_WORD / 8;
    localparam logic [3:0]       c_wait       = 4'(WAIT_STATES);
    localparam logic [c_idx_w-1:0] c_status_idx = c_idx_w'(NUM_REGS);

    logic [c_idx_w-1:0]            w_idx;
    logic                          w_access;
    logic                          w_pready;
    logic                          w_err;
    logic                          w_commit;
    logic [AMBA_WORD-1:0]          w_rd_word;
    logic                          unused_paddr;

    logic [3:0]                    cnt_q, cnt_d;
    logic [NUM_REGS*AMBA_WORD-1:0] regs_q, regs_d;
    logic [AMBA_WORD-1:0]          prdata_q, prdata_d;
    logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;
    logic                          start_q, start_d;

    assign unused_paddr = ^PADDR;

    always_comb begin
        w_idx    = PADDR[ADDR_LSB +: c_idx_w];
        w_access = PSEL & PENABLE;
        // Gated by rst so PREADY stays low throughout reset even at zero wait.
        w_pready = rst & w_access & (cnt_q == c_wait);
        w_err    = (w_idx > c_status_idx) |
                   (PWRITE & ((w_idx == c_status_idx) | busy_i));
        w_commit = w_pready & PWRITE & ~w_err;

        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == c_idx_w'(i)) begin
                w_rd_word = regs_q[i*AMBA_WORD +: AMBA_WORD];
            end
        end
        if (w_idx == c_status_idx) begin
            w_rd_word = status_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!PSEL || w_pready) begin
            cnt_d = '0;
        end else if (w_access && (cnt_q < c_wait)) begin
            cnt_d = cnt_q + 4'd1;
        end

        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_idx == c_idx_w'(i)) begin
                    for (int b = 0; b < c_nbytes; b++) begin
                        if (PSTRB[b]) begin
                            regs_d[i*AMBA_WORD + b*8 +: 8] = PWDATA[b*8 +: 8];
                        end
                    end
                    wr_pulse_d[i] = 1'b1;
                end
            end
        end
        // Register 0 bit 0 is the GO strobe: it pulses start_o and is never stored.
        start_d   = w_commit & (w_idx == '0) & PSTRB[0] & PWDATA[0];
        regs_d[0] = 1'b0;

        prdata_d = (PSEL & ~PENABLE & ~PWRITE) ? w_rd_word : prdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            regs_q     <= '0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            start_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            regs_q     <= regs_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            start_q    <= start_d;
        end
    end

    assign PREADY     = w_pready;
    assign PSLVERR    = w_pready & w_err;
    assign PRDATA     = prdata_q;
    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;
    assign start_o    = start_q;

endmodule
`default_nettype wire
